// File: rtl/mesh_load_sequencer_pkg.sv
// mesh_seq_pkg: shared state, loader command and PMU address definitions
package mesh_seq_pkg;
  localparam int PMU_ADDR_W = 5;
  typedef enum logic [2:0] {LOAD, START, SETTLE, RUN, DUMP_ADDR, DUMP_OUT, DONE} seq_state_t;
  typedef struct packed {
    logic [4:0] id;
    logic       write;
    logic [7:0] axlen;
    logic       resp_wait;
  } loader_cmd_t;
endpackage

// File: rtl/mesh_load_sequencer_if.sv
// mesh_load_sequencer_if: host command, loader fan-out, PMU and readout signals
interface mesh_load_sequencer_if import mesh_seq_pkg::*; #(
  parameter int N = 16,
  parameter int TIMEOUT_W = 24
);
  localparam int NODE_W = $clog2(N);
  logic                            cmd_valid_i;
  logic                            cmd_ready_o;
  logic [NODE_W-1:0]               cmd_node_i;
  logic [4:0]                      cmd_id_i;
  logic                            cmd_write_i;
  logic [7:0]                      cmd_axlen_i;
  logic                            cmd_resp_wait_i;
  logic                            run_i;
  logic [TIMEOUT_W-1:0]            timeout_i;
  logic [N-1:0]                    fifo_push_o;
  logic [N-1:0][4:0]               id_o;
  logic [N-1:0]                    write_o;
  logic [N-1:0][7:0]               axlen_o;
  logic [N-1:0]                    resp_wait_o;
  logic                            start_o;
  logic [N-1:0]                    idle_i;
  logic [N-1:0][PMU_ADDR_W-1:0]    pmu_addr_o;
  logic [N-1:0][31:0]              pmu_data_i;
  logic                            rd_valid_o;
  logic                            rd_ready_i;
  logic [NODE_W-1:0]               rd_node_o;
  logic [PMU_ADDR_W-1:0]           rd_reg_o;
  logic [31:0]                     rd_data_o;
  logic                            rd_last_o;
  logic                            busy_o;
  logic                            timeout_o;
  logic [TIMEOUT_W-1:0]            run_cycles_o;
  modport slave (
    input  cmd_valid_i, cmd_node_i, cmd_id_i, cmd_write_i, cmd_axlen_i, cmd_resp_wait_i,
           run_i, timeout_i, idle_i, pmu_data_i, rd_ready_i,
    output cmd_ready_o, fifo_push_o, id_o, write_o, axlen_o, resp_wait_o, start_o,
           pmu_addr_o, rd_valid_o, rd_node_o, rd_reg_o, rd_data_o, rd_last_o,
           busy_o, timeout_o, run_cycles_o
  );
  modport master (
    output cmd_valid_i, cmd_node_i, cmd_id_i, cmd_write_i, cmd_axlen_i, cmd_resp_wait_i,
           run_i, timeout_i, idle_i, pmu_data_i, rd_ready_i,
    input  cmd_ready_o, fifo_push_o, id_o, write_o, axlen_o, resp_wait_o, start_o,
           pmu_addr_o, rd_valid_o, rd_node_o, rd_reg_o, rd_data_o, rd_last_o,
           busy_o, timeout_o, run_cycles_o
  );
endinterface

// File: rtl/mesh_load_sequencer_pmu_sweep_ctrl.sv
// pmu_sweep_ctrl: reg-major sweep of all PMU registers with a one-beat valid/ready holding stage
module pmu_sweep_ctrl import mesh_seq_pkg::*; #(
  parameter int N = 16,
  parameter int PMU_REGS = 32,
  parameter int NODE_W = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic [PMU_ADDR_W-1:0]      pmu_addr,
  input  logic [N-1:0][31:0]         pmu_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NODE_W-1:0]          rd_node,
  output logic [PMU_ADDR_W-1:0]      rd_reg,
  output logic [31:0]                rd_data,
  output logic                       rd_last,
  output logic                       done
);
  logic active, out_ph, last_n, last_r;
  logic [NODE_W-1:0] n;
  logic [PMU_ADDR_W-1:0] r;
  assign last_n = n == NODE_W'(N - 1);
  assign last_r = r == PMU_ADDR_W'(PMU_REGS - 1);
  // Address phase presents r for one cycle; out phase captures the node's data and holds it until accepted
  always_ff @(posedge clk)
    if (rst) begin
      active <= 1'b0;
      out_ph <= 1'b0;
      n <= '0;
      r <= '0;
      pmu_addr <= '0;
      rd_valid <= 1'b0;
      rd_node <= '0;
      rd_reg <= '0;
      rd_data <= '0;
      rd_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        active <= 1'b1;
        out_ph <= 1'b0;
        n <= '0;
        r <= '0;
        pmu_addr <= '0;
      end else if (active && !out_ph) out_ph <= 1'b1;
      else if (active && !rd_valid) begin
        rd_valid <= 1'b1;
        rd_data <= pmu_data[n];
        rd_node <= n;
        rd_reg <= r;
        rd_last <= last_n && last_r;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        n <= last_n ? '0 : n + NODE_W'(1);
        if (last_n) begin
          out_ph <= 1'b0;
          r <= r + PMU_ADDR_W'(1);
          pmu_addr <= r + PMU_ADDR_W'(1);
          active <= !last_r;
          done <= last_r;
        end
      end
    end
endmodule

// File: rtl/mesh_load_sequencer.sv
// mesh_load_sequencer: fills loader FIFOs, starts the mesh, waits for drain, then streams out all PMU registers
module mesh_load_sequencer import mesh_seq_pkg::*; #(
  parameter int N = 16,
  parameter int PMU_REGS = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_W = 24
) (
  input logic aclk,
  input logic areset,
  mesh_load_sequencer_if.slave bus
);
  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  seq_state_t state;
  logic [SET_W-1:0] settle;
  logic go, done, accept, node_ok;
  logic [PMU_ADDR_W-1:0] addr;
  logic [TIMEOUT_W-1:0] rc_sat;
  loader_cmd_t cmd;
  assign accept = bus.cmd_valid_i && bus.cmd_ready_o;
  assign node_ok = 32'(bus.cmd_node_i) < N;
  assign cmd = '{bus.cmd_id_i, bus.cmd_write_i, bus.cmd_axlen_i, bus.cmd_resp_wait_i};
  assign rc_sat = bus.run_cycles_o + TIMEOUT_W'(bus.run_cycles_o != '1);
  assign bus.pmu_addr_o = {N{addr}};
  // Sequencer FSM; every output is registered, pushes are independent of state since ready gates accepts
  always_ff @(posedge aclk)
    if (areset) begin
      state <= LOAD;
      settle <= '0;
      go <= 1'b0;
      bus.cmd_ready_o <= 1'b1;
      bus.busy_o <= 1'b0;
      bus.start_o <= 1'b0;
      bus.fifo_push_o <= '0;
      bus.id_o <= '0;
      bus.write_o <= '0;
      bus.axlen_o <= '0;
      bus.resp_wait_o <= '0;
      bus.timeout_o <= 1'b0;
      bus.run_cycles_o <= '0;
    end else begin
      bus.start_o <= 1'b0;
      go <= 1'b0;
      bus.fifo_push_o <= (accept && node_ok) ? {{(N-1){1'b0}}, 1'b1} << bus.cmd_node_i : '0;
      if (accept && node_ok) begin
        bus.id_o[bus.cmd_node_i] <= cmd.id;
        bus.write_o[bus.cmd_node_i] <= cmd.write;
        bus.axlen_o[bus.cmd_node_i] <= cmd.axlen;
        bus.resp_wait_o[bus.cmd_node_i] <= cmd.resp_wait;
      end
      case (state)
        LOAD: if (bus.run_i) begin
          state <= START;
          bus.cmd_ready_o <= 1'b0;
          bus.start_o <= 1'b1;
          bus.busy_o <= 1'b1;
        end
        START: begin
          state <= SETTLE;
          settle <= '0;
          bus.run_cycles_o <= TIMEOUT_W'(1);
        end
        SETTLE: begin
          bus.run_cycles_o <= rc_sat;
          settle <= settle + SET_W'(1);
          if (settle == SET_W'(SETTLE_CYCLES - 1)) state <= RUN;
        end
        RUN: if (&bus.idle_i || (bus.timeout_i != '0 && bus.run_cycles_o >= bus.timeout_i)) begin
          state <= DUMP_ADDR;
          go <= 1'b1;
          bus.timeout_o <= !(&bus.idle_i);
        end else bus.run_cycles_o <= rc_sat;
        DUMP_ADDR: state <= DUMP_OUT;
        DUMP_OUT: if (done) state <= DONE;
        DONE: if (bus.run_i) begin
          state <= LOAD;
          bus.cmd_ready_o <= 1'b1;
          bus.busy_o <= 1'b0;
          bus.timeout_o <= 1'b0;
          bus.run_cycles_o <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  pmu_sweep_ctrl #(.N(N), .PMU_REGS(PMU_REGS)) u_sweep (
    .clk(aclk),
    .rst(areset),
    .go(go),
    .pmu_addr(addr),
    .pmu_data(bus.pmu_data_i),
    .rd_valid(bus.rd_valid_o),
    .rd_ready(bus.rd_ready_i),
    .rd_node(bus.rd_node_o),
    .rd_reg(bus.rd_reg_o),
    .rd_data(bus.rd_data_o),
    .rd_last(bus.rd_last_o),
    .done(done)
  );
endmodule
